// File: rtl/data_mem_master.sv
// data_mem_master: initiator side of the byte-lane data RAM.
// Turns one MEM-stage load/store into a RAM cycle. It handles big-endian lane
// select, store-data replication, alignment exceptions, the read-latency wait,
// and load extension. The pipeline is stalled until the access completes.
module data_mem_master #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              stallreq,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                         OP_LW = 3'd4, OP_SB  = 3'd5, OP_SH = 3'd6, OP_SW  = 3'd7;

  // The first WAIT cycle counts as one, so the counter starts at READ_LAT-1.
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [1:0]  wcnt;
  logic        is_store, store_q, misalign, accept, exc_take, last_rd;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d, load_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_store = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
  assign store_q  = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  // Alignment check, plus lane select and replicated store data for the request
  always_comb begin
    misalign = 1'b0;
    sel_d    = 4'b0000;
    wdata_d  = req_wdata;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: begin
        sel_d   = 4'b1000 >> req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        misalign = req_addr[0];
        sel_d    = req_addr[1] ? 4'b0011 : 4'b1100;
        wdata_d  = {2{req_wdata[15:0]}};
      end
      default: begin
        misalign = (req_addr[1:0] != 2'b00);
        sel_d    = 4'b1111;
      end
    endcase
  end

  // A flush in IDLE blocks both the accept and any exception report
  assign accept   = (state == S_IDLE) && req_valid && !flush && !misalign;
  assign exc_take = (state == S_IDLE) && req_valid && !flush &&  misalign;

  // Pick the load lanes out of the returned word (big-endian) and extend them
  always_comb begin
    byte_v = 8'h00;
    case (off_q)
      2'd0:    byte_v = ram_rdata[31:24];
      2'd1:    byte_v = ram_rdata[23:16];
      2'd2:    byte_v = ram_rdata[15:8];
      default: byte_v = ram_rdata[7:0];
    endcase
    half_v = off_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (op_q)
      OP_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_ext = {24'h0, byte_v};
      OP_LH:   load_ext = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_ext = {16'h0, half_v};
      OP_LW:   load_ext = ram_rdata;
      default: load_ext = 32'h0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; flush overrides everything and returns to IDLE
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept)        state_n = S_ACCESS;
        else if (exc_take) state_n = S_DONE;
      end
      S_ACCESS: state_n = (store_q || READ_LAT == 0) ? S_DONE : S_WAIT;
      S_WAIT:   if (wcnt == 2'd0) state_n = S_DONE;
      default:  state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  // The data phase ends on the edge that leaves ACCESS/WAIT for DONE
  assign last_rd = ((state == S_ACCESS) || (state == S_WAIT)) && (state_n == S_DONE);

  // Output logic
  always_comb begin
    ram_ce     = (state == S_ACCESS) || (state == S_WAIT);
    ram_we     = (state == S_ACCESS) && store_q;
    resp_valid = (state == S_DONE);
    stallreq   = ((state == S_IDLE) && req_valid && !flush) || ram_ce;
  end

  // Datapath registers: RAM drive latched at accept, response latched at completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_sel    <= '0;
      ram_wdata  <= '0;
      op_q       <= '0;
      off_q      <= '0;
      wcnt       <= '0;
      resp_rdata <= '0;
      exc_adel   <= 1'b0;
      exc_ades   <= 1'b0;
      bad_vaddr  <= '0;
    end else begin
      if (accept) begin
        ram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        ram_sel   <= sel_d;
        ram_wdata <= wdata_d;
        op_q      <= req_op;
        off_q     <= req_addr[1:0];
      end
      if (exc_take) begin
        resp_rdata <= '0;
        exc_adel   <= ~is_store;
        exc_ades   <= is_store;
        bad_vaddr  <= req_addr;
      end
      if (last_rd) begin
        resp_rdata <= store_q ? 32'h0 : load_ext;
        exc_adel   <= 1'b0;
        exc_ades   <= 1'b0;
      end
      if ((state == S_ACCESS) && (state_n == S_WAIT))   wcnt <= WAIT_INIT;
      else if ((state == S_WAIT) && (wcnt != 2'd0))     wcnt <= wcnt - 2'd1;
    end
  end

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator side of the data-RAM interface; sits between the MEM pipeline stage and the byte-lane data RAM (ce/we/addr/sel/data, 4 byte banks).
- Converts one load/store request (LB/LBU/LH/LHU/LW/SB/SH/SW) into RAM cycles: byte-lane selection, store-data replication, alignment checks, read-latency wait, load extraction and sign/zero extension.
- Stalls the pipeline until the access completes.

Parameters:
- READ_LAT, 1, RAM read latency in cycles: 0 = combinational data_o, 1 = registered data_o; legal range 0..3.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage memory request; held stable while stallreq=1
- req_op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- flush  in  1  pipeline flush; aborts the request in flight
- stallreq  out  1  stall request to the pipeline controller
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and exceptions
- exc_adel  out  1  load address error; valid with resp_valid
- exc_ades  out  1  store address error; valid with resp_valid
- bad_vaddr  out  ADDR_W  faulting address; valid with exc_*
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address, word-aligned (low 2 bits 0)
- ram_sel  out  4  byte-lane enables; sel[3] = data[31:24]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE.
  - All outputs 0: ram_*, resp_*, exc_*, bad_vaddr, read-wait counter.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE to ACCESS on accept, when req_valid=1 and the address is aligned.
  - IDLE to DONE when req_valid=1 and the address is misaligned. No RAM access occurs.
  - ACCESS to DONE for stores, or for loads when READ_LAT=0.
  - ACCESS to WAIT for loads when READ_LAT>0. WAIT lasts READ_LAT-1 further cycles (counter), then goes to DONE.
  - DONE to IDLE unconditionally. No request is accepted in DONE.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte ops are always aligned.
- Endianness is big-endian, byte offset k=addr[1:0]:
  - Byte ops: sel = 4'b1000 >> k.
  - Half ops: sel = 1100 at k=0, 0011 at k=2.
  - Word ops: sel = 1111.
- Store data: SB drives {4{wdata[7:0]}}, SH drives {2{wdata[15:0]}}, SW drives wdata.
- RAM drive:
  - ram_addr, ram_sel, ram_wdata and ram_we are registered at accept and held constant through ACCESS and WAIT.
  - ram_ce=1 only in ACCESS and WAIT.
  - ram_we=1 only in ACCESS and only for stores.
  - ram_ce=0 in IDLE and DONE.
- Load capture:
  - ram_rdata is sampled at the end of the last ACCESS/WAIT cycle: READ_LAT+1 cycles after accept.
  - Extraction: byte k = rdata[31-8k -: 8]; half at k=0 = [31:16], k=2 = [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Response:
  - resp_valid=1 for exactly one cycle, in DONE.
  - resp_rdata, exc_* and bad_vaddr are registered and valid in that cycle.
  - These registers hold their values afterwards; only resp_valid returns to 0.
- Latency from the accept cycle T:
  - store: resp at T+2.
  - load: resp at T+2+READ_LAT.
  - exception: resp at T+1.
- stallreq = (IDLE and req_valid and not flush) or ACCESS or WAIT. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Flush:
  - flush=1 in any state sends the FSM to IDLE on the next edge.
  - No resp_valid is produced for the aborted request.
  - A store already in ACCESS still writes that cycle; flush only suppresses the response.
  - flush in IDLE blocks the accept.
- Simultaneous flush and misalignment in IDLE: flush wins; no exception is reported.
- Reset mid-access: outputs are cleared immediately; a partial RAM cycle is abandoned.

Test Plan:
- SW addr=0x10 wdata=0xAABBCCDD -> ACCESS cycle: ram_ce=1, ram_we=1, ram_addr=0x10, ram_sel=1111, ram_wdata=0xAABBCCDD; resp_valid at T+2; stallreq high in cycles T, T+1.
- SB addr=0x13 wdata=0x5A -> ram_sel=0001, ram_wdata=0x5A5A5A5A; then LW 0x10 (READ_LAT=1) with RAM returning 0xAABBCC5A -> resp_rdata=0xAABBCC5A at T+3.
- LB addr=0x11 with ram_rdata=0x12F45678 -> resp_rdata=0xFFFFFFF4; LBU same address -> 0x000000F4; LH 0x12 with rdata 0x12348001 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x22 -> no ram_ce; at T+1 resp_valid=1, exc_adel=1, bad_vaddr=0x22. SH addr=0x21 -> exc_ades=1, bad_vaddr=0x21.
- READ_LAT=3 load -> ram_ce held for 4 cycles with a constant address; resp at T+5; ram_rdata sampled at the end of cycle T+4 only.
- flush asserted during WAIT -> no resp_valid, IDLE next cycle, stallreq=0; rst_n low mid-ACCESS -> ram_ce=0 and resp_valid=0 immediately.
